e_mdu: RTL

//   Execute-stage multiply/divide unit: owns the architectural HI/LO registers and produces
//   E_HI/E_LO, which are piped to M_HI/M_LO and W_HI/W_LO for the forwarding and RFWD muxes.

---
 rtl/mdu_pkg.sv | 30 +++
 rtl/mdu_calc.sv | 72 +++++++
 rtl/e_mdu.sv | 117 +++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared op codes, default latencies and helpers for the execute-stage multiply/divide unit.
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_NONE  = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6
    } mdu_op_e;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_RUN  = 1'b1
    } mdu_state_e;

    localparam int MDU_MULT_CYCLES = 5;
    localparam int MDU_DIV_CYCLES  = 10;

    function automatic logic is_calc_op(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational mult/div datapath: 64-bit {hi,lo} for the requested op plus a divide-by-zero flag.
module mdu_calc
    import mdu_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        div0_o
);

    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic               a_neg;
    logic               b_neg;
    logic               signed_div;
    logic [31:0]        mag_a;
    logic [31:0]        mag_b;
    logic [31:0]        dividend;
    logic [31:0]        divisor;
    logic [31:0]        quot;
    logic [31:0]        rem;

    assign prod_s = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
    assign prod_u = {32'd0, a_i} * {32'd0, b_i};

    // Signed division runs on magnitudes; 0x80000000 keeps its bit pattern as an unsigned
    // magnitude, which makes 0x80000000 / -1 fall out as 0x80000000 without a special case.
    assign a_neg      = a_i[31];
    assign b_neg      = b_i[31];
    assign signed_div = (op_i == MDU_DIV);
    assign mag_a      = a_neg ? (~a_i + 32'd1) : a_i;
    assign mag_b      = b_neg ? (~b_i + 32'd1) : b_i;
    assign dividend   = signed_div ? mag_a : a_i;
    // A zero divisor is swapped for 1 so the divider never sees x/0; the result is discarded.
    assign divisor    = (b_i == 32'd0) ? 32'd1 : (signed_div ? mag_b : b_i);
    assign quot       = dividend / divisor;
    assign rem        = dividend % divisor;

    always_comb begin
        hi_o   = 32'd0;
        lo_o   = 32'd0;
        div0_o = 1'b0;
        case (op_i)
            MDU_MULT: begin
                hi_o = prod_s[63:32];
                lo_o = prod_s[31:0];
            end
            MDU_MULTU: begin
                hi_o = prod_u[63:32];
                lo_o = prod_u[31:0];
            end
            MDU_DIV: begin
                lo_o   = (a_neg ^ b_neg) ? (~quot + 32'd1) : quot;
                hi_o   = a_neg ? (~rem + 32'd1) : rem;
                div0_o = (b_i == 32'd0);
            end
            MDU_DIVU: begin
                lo_o   = quot;
                hi_o   = rem;
                div0_o = (b_i == 32'd0);
            end
            default: begin
                hi_o   = 32'd0;
                lo_o   = 32'd0;
                div0_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: owns HI/LO, computes at start, then holds the result in a
// shadow register until the busy counter expires and commits it.
module e_mdu #(
    parameter int MULT_CYCLES = mdu_pkg::MDU_MULT_CYCLES,
    parameter int DIV_CYCLES  = mdu_pkg::MDU_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        E_Start,
    input  logic [2:0]  E_MDUOp,
    input  logic [31:0] E_FALUA,
    input  logic [31:0] E_FALUB,
    input  logic        E_Flush,
    output logic        E_Busy,
    output logic [31:0] E_HI,
    output logic [31:0] E_LO
);

    import mdu_pkg::*;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      sh_hi_q, sh_hi_d;
    logic [31:0]      sh_lo_q, sh_lo_d;
    logic             sh_div0_q, sh_div0_d;

    logic [31:0]      calc_hi;
    logic [31:0]      calc_lo;
    logic             calc_div0;
    logic             start;

    mdu_calc u_calc (
        .op_i   (E_MDUOp),
        .a_i    (E_FALUA),
        .b_i    (E_FALUB),
        .hi_o   (calc_hi),
        .lo_o   (calc_lo),
        .div0_o (calc_div0)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= MDU_IDLE;
            cnt_q     <= '0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            sh_hi_q   <= 32'd0;
            sh_lo_q   <= 32'd0;
            sh_div0_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            sh_hi_q   <= sh_hi_d;
            sh_lo_q   <= sh_lo_d;
            sh_div0_q <= sh_div0_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        sh_hi_d   = sh_hi_q;
        sh_lo_d   = sh_lo_q;
        sh_div0_d = sh_div0_q;
        start     = 1'b0;
        case (state_q)
            MDU_IDLE: begin
                start = E_Start && !E_Flush && is_calc_op(E_MDUOp);
                if (start) begin
                    sh_hi_d   = calc_hi;
                    sh_lo_d   = calc_lo;
                    sh_div0_d = calc_div0;
                    cnt_d     = is_div_op(E_MDUOp) ? DIV_CNT : MULT_CNT;
                    state_d   = MDU_RUN;
                end else if (!E_Flush && (E_MDUOp == MDU_MTHI)) begin
                    hi_d = E_FALUA;
                end else if (!E_Flush && (E_MDUOp == MDU_MTLO)) begin
                    lo_d = E_FALUA;
                end
            end
            MDU_RUN: begin
                // Starts and moves are ignored here; upstream is stalled on E_Busy anyway.
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = MDU_IDLE;
                    if (!sh_div0_q) begin
                        hi_d = sh_hi_q;
                        lo_d = sh_lo_q;
                    end
                end
            end
            default: begin
                state_d = MDU_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        E_Busy = (state_q == MDU_RUN);
        E_HI   = hi_q;
        E_LO   = lo_q;
    end

endmodule
